alu_op_sequencer: RTL and testbench

Registered issue stage directly upstream of the combinational 32-bit ALU. It accepts one operation (A, B, 3-bit Ctl) per valid/ready handshake and drives the ALU operand and control inputs from stable registers. It captures the ALU result and flags into an output register with its own valid/ready handshake. It also implements the ALU's vacant MUL opcode as a 32-cycle shift-add loop that reuses the ALU's ADD path.

---
 rtl/alu_op_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Registered issue stage in front of the combinational 32-bit ALU, with a result register and
// valid/ready on both sides. Define ALU_SEQ_MUL_EN to run opcode 4 as a 32-step shift-add MUL.
module alu_op_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctl,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_overflow,
  output logic        out_cout,
  output logic        out_err
);

  localparam logic [2:0] CtlAdd = 3'd0;
  localparam logic [2:0] CtlMul = 3'd4;

  typedef enum logic [1:0] {StIdle, StExec, StMul, StHold} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_alu_a, r_alu_b;
  logic [2:0]  r_alu_ctl;
  logic        r_out_valid, r_out_zero, r_out_overflow, r_out_cout, r_out_err;
  logic [31:0] r_out_result;
  logic        w_accept, w_go_mul, w_vacant;

  assign in_ready = reset_n & ((r_state == StIdle) | ((r_state == StHold) & out_ready));
  assign w_accept = in_valid & in_ready;

`ifdef ALU_SEQ_MUL_EN
  // The alu_a register doubles as the accumulator P.
  logic [31:0] r_m, r_q;
  logic [4:0]  r_cnt;
  logic [31:0] w_m_next, w_q_next;

  assign w_go_mul = (in_ctl == CtlMul);
  assign w_vacant = 1'b0;
  assign w_m_next = r_m << 1;
  assign w_q_next = r_q >> 1;
`else
  assign w_go_mul = 1'b0;
  assign w_vacant = (r_alu_ctl == CtlMul);
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = w_go_mul ? StMul : StExec;
      end
      StExec: w_state_next = StHold;
      StMul: begin
`ifdef ALU_SEQ_MUL_EN
        if (r_cnt == 5'd31) w_state_next = StHold;
`else
        w_state_next = StIdle;
`endif
      end
      StHold: begin
        if (out_ready) begin
          if (w_accept) w_state_next = w_go_mul ? StMul : StExec;
          else          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_ctl      <= '0;
      r_out_valid    <= 1'b0;
      r_out_result   <= '0;
      r_out_zero     <= 1'b0;
      r_out_overflow <= 1'b0;
      r_out_cout     <= 1'b0;
      r_out_err      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_m            <= '0;
      r_q            <= '0;
      r_cnt          <= '0;
`endif
    end else begin
      if (r_state == StHold && out_ready) r_out_valid <= 1'b0;

      if (w_accept) begin
        r_alu_a   <= in_a;
        r_alu_b   <= in_b;
        r_alu_ctl <= in_ctl;
`ifdef ALU_SEQ_MUL_EN
        r_m       <= in_a;
        r_q       <= in_b;
        r_cnt     <= '0;
        if (w_go_mul) begin
          r_alu_a   <= '0;
          r_alu_b   <= in_b[0] ? in_a : '0;
          r_alu_ctl <= CtlAdd;
        end
`endif
      end

      if (r_state == StExec) begin
        r_out_valid <= 1'b1;
        if (w_vacant) begin
          r_out_result   <= '0;
          r_out_zero     <= 1'b0;
          r_out_overflow <= 1'b0;
          r_out_cout     <= 1'b0;
          r_out_err      <= 1'b1;
        end else begin
          r_out_result   <= alu_out;
          r_out_zero     <= alu_zero;
          r_out_overflow <= alu_overflow;
          r_out_cout     <= alu_cout;
          r_out_err      <= 1'b0;
        end
      end

`ifdef ALU_SEQ_MUL_EN
      if (r_state == StMul) begin
        r_alu_a <= alu_out;
        r_alu_b <= w_q_next[0] ? w_m_next : '0;
        r_m     <= w_m_next;
        r_q     <= w_q_next;
        r_cnt   <= r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          r_out_valid    <= 1'b1;
          r_out_result   <= alu_out;
          r_out_zero     <= (alu_out == '0);
          r_out_overflow <= 1'b0;
          r_out_cout     <= 1'b0;
          r_out_err      <= 1'b0;
        end
      end
`endif
    end
  end

  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_ctl      = r_alu_ctl;
  assign out_valid    = r_out_valid;
  assign out_result   = r_out_result;
  assign out_zero     = r_out_zero;
  assign out_overflow = r_out_overflow;
  assign out_cout     = r_out_cout;
  assign out_err      = r_out_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: models the downstream ALU and predicts each result
// from plain arithmetic; follows ALU_SEQ_MUL_EN to pick MUL or vacant-opcode expectations.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MulOn = 1'b1;
`else
  localparam bit MulOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [2:0]  in_ctl = '0;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_ctl;
  logic        alu_zero, alu_overflow, alu_cout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero, out_overflow, out_cout, out_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_ctl(in_ctl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_overflow(out_overflow), .out_cout(out_cout), .out_err(out_err)
  );

  // ALU behaviour: returns {cout, overflow, zero, result}. Opcode 4 is vacant and yields junk.
  function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic ov, co;
    ov = 1'b0; co = 1'b0; r = '0; s = '0;
    case (c)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: begin r = 32'hDEADBEEF; ov = 1'b1; co = 1'b1; end
      3'd5: r = b << a[4:0];
      3'd6: r = $signed(b) >>> a[4:0];
      default: r = b >> a[4:0];
    endcase
    return {co, ov, (r == 32'd0), r};
  endfunction

  assign {alu_cout, alu_overflow, alu_zero, alu_out} = alu_fn(alu_a, alu_b, alu_ctl);

  // Expected capture: {err, cout, overflow, zero, result}.
  function automatic logic [35:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] c);
    if (c == 3'd4) begin
`ifdef ALU_SEQ_MUL_EN
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      return {1'b0, 1'b0, 1'b0, (p[31:0] == 32'd0), p[31:0]};
`else
      return {1'b1, 35'd0};
`endif
    end
    return {1'b0, alu_fn(a, b, c)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Call at a negedge. Issues one op (optionally popping the held result at the same edge),
  // waits for the result and checks latency, busy in_ready and captured values.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                       input bit pop_prev, input string tag);
    logic [35:0] e;
    int n, lat;
    e   = ref_op(a, b, c);
    lat = (c == 3'd4 && MulOn) ? 32 : 1;
    in_a = a; in_b = b; in_ctl = c; in_valid = 1'b1; out_ready = pop_prev;
    #1;
    chk({tag, ".in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk({tag, ".valid_drop"}, out_valid, 0);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      chk({tag, ".busy"}, in_ready, 0);
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".result"}, out_result, e[31:0]);
    chk({tag, ".zero"}, out_zero, e[32]);
    chk({tag, ".ovf"}, out_overflow, e[33]);
    chk({tag, ".cout"}, out_cout, e[34]);
    chk({tag, ".err"}, out_err, e[35]);
    last_res = e[31:0];
  endtask

  task automatic hold(input int k, input string tag);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_result"}, out_result, last_res);
      chk({tag, ".hold_ready"}, in_ready, 0);
    end
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    #1;
    chk({tag, ".pop_ready"}, in_ready, 1);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".pop_valid"}, out_valid, 0);
    chk({tag, ".idle_ready"}, in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pending, chain;
    logic [31:0] ra, rb;
    logic [2:0]  rc;

    repeat (3) @(negedge clk);
    chk("rst.in_ready_low", in_ready, 0);
    reset_n = 1'b1;
    #1;
    chk("rst.valid", out_valid, 0);
    chk("rst.result", out_result, 0);
    chk("rst.err", out_err, 0);
    chk("rst.alu_a", alu_a, 0);
    chk("rst.alu_ctl", alu_ctl, 0);
    chk("rst.in_ready", in_ready, 1);
    @(negedge clk);

    issue(32'd5, 32'd7, 3'd0, 1'b0, "add");
    pop("add");
    issue(32'd3, 32'd3, 3'd1, 1'b0, "sub");
    issue(32'hFFFF_FFFF, 32'd1, 3'd3, 1'b1, "slt");
    pop("slt");
    issue(32'd1234, 32'd5678, 3'd4, 1'b0, "mul");
    pop("mul");
    issue(32'h1_0000, 32'h1_0000, 3'd4, 1'b0, "mul0");
    pop("mul0");
    issue(32'd1, 32'd1, 3'd0, 1'b0, "hold");
    hold(5, "hold");
    issue(32'h0000_F0F0, 32'h0000_0FF0, 3'd2, 1'b1, "xor");
    pop("xor");

    // Reset in the middle of a MUL loop.
    in_a = 32'd1234; in_b = 32'd5678; in_ctl = 3'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst.in_ready_low", in_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midrst.valid", out_valid, 0);
    chk("midrst.result", out_result, 0);
    chk("midrst.alu_a", alu_a, 0);
    chk("midrst.alu_b", alu_b, 0);
    chk("midrst.in_ready", in_ready, 1);
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("midrst.stays_idle", out_valid, 0);
    end
    issue(32'd2, 32'd2, 3'd0, 1'b0, "add2");
    pop("add2");
    issue(32'd3, 32'd4, 3'd4, 1'b0, "mul34");
    pop("mul34");

    pending = 1'b0;
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = (i % 5 == 0) ? ra : $urandom;
      rc = 3'($urandom_range(0, 7));
      chain = pending && ($urandom_range(0, 1) == 1);
      if (pending && !chain) pop("rnd");
      issue(ra, rb, rc, chain, "rnd");
      hold($urandom_range(0, 2), "rnd");
      pending = 1'b1;
    end
    pop("rnd_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
